// File: rtl/seg7_scan.sv
`default_nettype none
// ====================================================================
// Module   : seg7_scan
// Purpose  : Multiplexed 7-segment scanner, anode gap between digits,
//            shadowed display inputs. Define SEG7_SCAN_LZ_BLANK_EN
//            to enable leading-zero blanking.
// Revision : 1.0 - initial release
// ====================================================================
module seg7_scan #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] val,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int c_PW = $clog2(REFRESH_DIV);
  localparam int c_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int c_IW = $clog2(NUM_DIGITS);

  localparam logic [c_PW-1:0]       c_SHOW_LAST = c_PW'(REFRESH_DIV - 1);
  localparam logic [c_GW-1:0]       c_GAP_LAST  = c_GW'(GAP_CYCLES - 1);
  localparam logic [c_IW-1:0]       c_IDX_LAST  = c_IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_AN_ONE    = NUM_DIGITS'(1);

  typedef enum logic [0:0] {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [c_PW-1:0]         r_cnt, w_cnt_nxt;
  logic [c_GW-1:0]         r_gap, w_gap_nxt;
  logic [c_IW-1:0]         r_idx, w_idx_nxt;
  logic [7:0]              r_seg, w_seg_nxt;
  logic [NUM_DIGITS-1:0]   r_an, w_an_nxt;

  logic [4*NUM_DIGITS-1:0] r_val;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;

  logic [3:0]              w_nibs [NUM_DIGITS];
  logic                    w_auto_blank;
  logic [7:0]              w_glyph;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0011000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
    assign w_nibs[k] = r_val[4*k +: 4];
  end

`ifdef SEG7_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz;

  // A digit is a leading zero while every digit above it is also zero.
  always_comb begin
    logic w_run;
    w_run = 1'b1;
    w_lz  = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_run   = w_run & (w_nibs[k] == 4'h0);
      w_lz[k] = w_run;
    end
  end

  assign w_auto_blank = w_lz[r_idx];
`else
  assign w_auto_blank = 1'b0;
`endif

  // Forced blank darkens the dp as well; auto-blank keeps the dp request.
  always_comb begin
    w_glyph = 8'hFF;
    if (!r_blank[r_idx]) begin
      if (w_auto_blank) begin
        w_glyph = {~r_dp[r_idx], 7'h7F};
      end else begin
        w_glyph = {~r_dp[r_idx], hex7(w_nibs[r_idx])};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_idx_nxt   = r_idx;
    w_seg_nxt   = r_seg;
    w_an_nxt    = r_an;
    case (r_state)
      ST_GAP: begin
        if (r_gap == c_GAP_LAST) begin
          w_state_nxt = ST_SHOW;
          w_gap_nxt   = '0;
          w_an_nxt    = ~(c_AN_ONE << r_idx);
          w_seg_nxt   = w_glyph;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      ST_SHOW: begin
        if (r_cnt == c_SHOW_LAST) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
          w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
          w_an_nxt    = '1;
          w_seg_nxt   = 8'hFF;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_GAP;
        w_an_nxt    = '1;
        w_seg_nxt   = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_GAP;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_idx   <= '0;
      r_seg   <= 8'hFF;
      r_an    <= '1;
      r_val   <= '0;
      r_dp    <= '0;
      r_blank <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_idx   <= w_idx_nxt;
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      if (load) begin
        r_val   <= val;
        r_dp    <= dp_in;
        r_blank <= blank;
      end
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// Testbench for seg7_scan: vector table, directed corner sequences and
// randomized traffic checked against a cycle-position reference model.
module tb_seg7_scan;

  localparam int N = 4;
  localparam int R = 4;
  localparam int G = 1;
  localparam int P = G + R;

  logic          clk;
  logic          rst;
  logic [4*N-1:0] val;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  blank;
  logic          load;
  logic [7:0]    seg;
  logic [N-1:0]  an;

  int vectors     = 0;
  int miscompares = 0;

  seg7_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(G)) dut (
    .clk  (clk),
    .rst  (rst),
    .val  (val),
    .dp_in(dp_in),
    .blank(blank),
    .load (load),
    .seg  (seg),
    .an   (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0] glyph_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

`ifdef SEG7_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  // Reference model: position in the scan frame derives from edges since reset.
  int          m_e;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_blank;
  logic [3:0]  m_an;
  logic [7:0]  m_seg;

  function automatic logic [7:0] model_glyph(input int d);
    logic [3:0] n;
    bit lead;
    n = m_val[4*d +: 4];
    lead = (d != 0) && (n == 4'h0);
    for (int k = N - 1; k > d; k--) if (m_val[4*k +: 4] != 4'h0) lead = 1'b0;
    if (m_blank[d]) return 8'hFF;
    if (LZ && lead) return {~m_dp[d], 7'h7F};
    return {~m_dp[d], glyph_tbl[n]};
  endfunction

  task automatic model_edge();
    int s, d, w;
    if (rst) begin
      m_e = 0; m_an = 4'hF; m_seg = 8'hFF;
      m_val = '0; m_dp = '0; m_blank = 4'hF;
    end else begin
      m_e++;
      s = m_e % (N * P);
      d = s / P;
      w = s % P;
      if (w == G) begin
        m_an  = 4'hF ^ (4'b0001 << d);
        m_seg = model_glyph(d);
      end else if (w < G) begin
        m_an  = 4'hF;
        m_seg = 8'hFF;
      end
      if (load) begin
        m_val = val; m_dp = dp_in; m_blank = blank;
      end
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] b);
    rst = r; load = l; val = v; dp_in = d; blank = b;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] ea, input logic [7:0] es);
    vectors++;
    if (an !== ea || seg !== es) begin
      miscompares++;
      $display("FAIL %s: got an=%b seg=%b, expected an=%b seg=%b", name, an, seg, ea, es);
    end
  endtask

  task automatic reset3();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  typedef struct {
    logic        rst;
    logic        load;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  an;
    logic [7:0]  seg;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic l, input logic [15:0] v,
                     input logic [3:0] d, input logic [3:0] b,
                     input logic [3:0] ea, input logic [7:0] es);
    vec_t x;
    x.rst = r; x.load = l; x.val = v; x.dp = d; x.blank = b; x.an = ea; x.seg = es;
    for (int i = 0; i < n; i++) tbl.push_back(x);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; val = '0; dp_in = '0; blank = '0;
    m_e = 0; m_val = '0; m_dp = '0; m_blank = 4'hF; m_an = 4'hF; m_seg = 8'hFF;

    // Basic scan of 1234; load=0 rows carry junk inputs that must be ignored.
    add(3, 1, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 8'hFF);
    add(1, 0, 1, 16'h1234, 4'h0, 4'h0, 4'hE, 8'hFF);
    add(3, 0, 0, 16'hEEEE, 4'hF, 4'hF, 4'hE, 8'hFF);
    add(1, 0, 0, 16'hEEEE, 4'hF, 4'hF, 4'hF, 8'hFF);
    add(4, 0, 0, 16'hEEEE, 4'hF, 4'hF, 4'hD, 8'hB0);
    add(1, 0, 0, 16'hEEEE, 4'hF, 4'hF, 4'hF, 8'hFF);
    add(4, 0, 0, 16'hEEEE, 4'hF, 4'hF, 4'hB, 8'hA4);
    add(1, 0, 0, 16'hEEEE, 4'hF, 4'hF, 4'hF, 8'hFF);
    add(4, 0, 0, 16'hEEEE, 4'hF, 4'hF, 4'h7, 8'hF9);
    add(1, 0, 0, 16'hEEEE, 4'hF, 4'hF, 4'hF, 8'hFF);
    add(4, 0, 0, 16'hEEEE, 4'hF, 4'hF, 4'hE, 8'h99);
    add(1, 0, 0, 16'hEEEE, 4'hF, 4'hF, 4'hF, 8'hFF);
    add(4, 0, 0, 16'hEEEE, 4'hF, 4'hF, 4'hD, 8'hB0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].load, tbl[i].val, tbl[i].dp, tbl[i].blank);
      check($sformatf("table[%0d]", i), tbl[i].an, tbl[i].seg);
    end

    // Decimal point only on digit 2.
    reset3();
    step(1'b0, 1'b1, 16'hABCD, 4'b0100, 4'h0);
    run(5);  check("dp_digit1", 4'hD, 8'hC6);
    run(5);  check("dp_digit2", 4'hB, 8'h03);
    run(5);  check("dp_digit3", 4'h7, 8'h88);
    run(5);  check("dp_digit0", 4'hE, 8'hA1);

    // Reload mid-SHOW: lit digit frozen until its gap.
    reset3();
    step(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0);
    run(6);  check("reload_pre", 4'hD, 8'hB0);
    step(1'b0, 1'b1, 16'h5678, 4'h0, 4'h0);
    check("reload_edge", 4'hD, 8'hB0);
    run(1);  check("reload_hold", 4'hD, 8'hB0);
    run(1);  check("reload_gap", 4'hF, 8'hFF);
    run(1);  check("reload_digit2", 4'hB, 8'h82);
    run(5);  check("reload_digit3", 4'h7, 8'h92);

    // Leading zeros.
    reset3();
    step(1'b0, 1'b1, 16'h0050, 4'h0, 4'h0);
    run(5);  check("lz_digit1", 4'hD, 8'h92);
    run(5);  check("lz_digit2", 4'hB, LZ ? 8'hFF : 8'hC0);
    run(5);  check("lz_digit3", 4'h7, LZ ? 8'hFF : 8'hC0);
    run(5);  check("lz_digit0", 4'hE, 8'hC0);

    // Reset wins over a simultaneous load mid-SHOW.
    reset3();
    step(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0);
    run(6);  check("rst_pre", 4'hD, 8'hB0);
    step(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'h0);
    check("rst_load_edge", 4'hF, 8'hFF);
    run(1);  check("rst_rel_digit0", 4'hE, 8'hFF);
    run(5);  check("rst_rel_digit1", 4'hD, 8'hFF);
    run(15); check("rst_rel_wrap", 4'hE, 8'hFF);

    // Randomized traffic against the reference model.
    reset3();
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), 16'($urandom),
           4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      check($sformatf("random[%0d]", i), m_an, m_seg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 8, number of multiplexed digits (legal 2..8).
REQ-002 SHALL provide parameter REFRESH_DIV, default 100000, clk cycles each digit is lit (legal >=2).
REQ-003 SHALL provide parameter GAP_CYCLES, default 4, clk cycles all anodes are off between digits (legal >=1).
REQ-004 SHALL provide port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL provide port val  input  4*NUM_DIGITS  hex nibbles, digit k = val[4k+3:4k], digit 0 rightmost.
REQ-007 SHALL provide port dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 SHALL provide port blank  input  NUM_DIGITS  per-digit forced blank, 1 = digit dark.
REQ-009 SHALL provide port load  input  1  one-cycle strobe capturing val, dp_in and blank into shadow registers.
REQ-010 SHALL provide port seg  output  8  registered, active-low; bit7 = dp, bits6:0 = g..a.
REQ-011 SHALL provide port an  output  NUM_DIGITS  registered, active-low anode enables.

Function
REQ-012 SHALL decode nibbles 0-F to hex glyphs (seg[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-013 SHALL drive seg[7] = ~dp of the digit being shown.
REQ-014 SHALL implement two states: GAP (an all 1, seg 8'hFF) and SHOW (exactly one an bit low).
REQ-015 SHALL stay in GAP exactly GAP_CYCLES cycles, then enter SHOW with an[idx]=0 and seg = decode of shadow digit idx, both updating on the same edge.
REQ-016 SHALL stay in SHOW exactly REFRESH_DIV cycles, then enter GAP and increment idx, wrapping NUM_DIGITS-1 -> 0.
REQ-017 SHALL compute seg only on the GAP->SHOW edge; shadow changes during SHOW SHALL NOT alter the lit digit.
REQ-018 SHALL update shadow registers on the edge where load=1; values take effect at the next GAP->SHOW edge.
REQ-019 SHALL output seg = 8'hFF (anode still enabled) for a SHOW digit whose shadow blank bit is 1, dp included.
REQ-020 SHALL ignore val, dp_in and blank when load=0.
REQ-021 SHALL size the prescaler to $clog2(REFRESH_DIV) bits and the index to $clog2(NUM_DIGITS) bits, with no overflow at maximum values.

Reset
REQ-022 SHALL, on any edge with rst=1, set seg=8'hFF, an all 1, state GAP, idx=0, counters 0, shadow val/dp 0 and shadow blank all 1.
REQ-023 SHALL give rst priority over load and over any state transition on the same edge.
REQ-024 SHALL, after rst deasserts, show digit 0 first, GAP_CYCLES cycles later.
REQ-025 SHALL abort a SHOW or GAP in progress when rst asserts mid-operation, with no partial-scan residue.

Configuration
REQ-026 SHALL recognise macro SEG7_SCAN_LZ_BLANK_EN.
REQ-027 With SEG7_SCAN_LZ_BLANK_EN defined, SHALL blank digits from NUM_DIGITS-1 downward whose shadow nibble is 0 up to the first nonzero digit; digit 0 never auto-blanked; dp of an auto-blanked digit still honoured.
REQ-028 Without SEG7_SCAN_LZ_BLANK_EN, SHALL show zeros in all positions; only the blank input darkens a digit.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1)
REQ-029 SHALL cover: rst 3 cycles, then load val=16'h1234, blank=0 -> repeating an sequence 1110,1111,1101,1111,1011,1111,0111,1111, segs 0011001,0110000,0100100,1111001; SHOW 4 cycles, GAP 1 cycle.
REQ-030 SHALL cover: load val=16'hABCD, dp_in=4'b0100 -> digit 2 seg=8'b00000011 (b with dp), other digits bit7=1.
REQ-031 SHALL cover: second load mid-SHOW of digit 1 -> digit 1 seg unchanged until its GAP; digit 2 shows the new nibble.
REQ-032 SHALL cover: val=16'h0050 with macro defined -> digits 3,2 seg=8'hFF, digit 1 = 0010010, digit 0 = 1000000; without macro digits 3,2 = 1000000.
REQ-033 SHALL cover: rst asserted while load=1 mid-SHOW -> next edge an=1111, seg=8'hFF, shadow unchanged by load; after release digit 0 lit at edge 1 and blanked (seg=8'hFF) until a load.
